watch_time_ctrl: RTL
====================

Name: watch_time_ctrl

Overview:
Sequencing controller for the watch's seconds, minutes and hours pulse-increment counters.
- Divides the system clock into a 1 Hz time base and a 2 Hz blink phase.
- Decides which counter receives an increment pulse each cycle: normal timekeeping in RUN, or user-driven single-field adjustment in the set modes.
- Sits between the debounced key logic and the three counters; drives the display blink mask.

Parameters:
HALF_PERIOD, 500, system clock cycles per half second (min 2); prescaler counter width = clog2(HALF_PERIOD)
REPEAT_DELAY, 2, half-periods key_inc must be held before auto-repeat starts (used only with AUTO_REPEAT_EN)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
key_mode  input  1  debounced mode key, single-cycle pulse per press
key_inc  input  1  debounced increment key, level (high while held)
sec_at_max  input  1  level, high while seconds counter holds its maximum value
min_at_max  input  1  level, high while minutes counter holds its maximum value
sec_pulse  output  1  increment pulse to seconds counter
min_pulse  output  1  increment pulse to minutes counter
hour_pulse  output  1  increment pulse to hours counter
sec_clear  output  1  synchronous clear request to seconds counter
set_mode  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
blink  output  1  display blank phase for the selected field; 0 in RUN

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - state RUN, prescaler count 0, phase 0.
  - All outputs 0: set_mode=0, blink=0.
  - key_inc edge register cleared to 0 (a key held through reset yields no pulse on release of reset).
- Prescaler:
  - Counts 0..HALF_PERIOD-1, wraps to 0 and toggles phase.
  - half_tick = one cycle at each wrap; sec_tick = half_tick while phase==1 (one per 2*HALF_PERIOD cycles).
- All outputs are registered: the response appears one cycle after the causing input or tick.
- RUN state:
  - sec_pulse = sec_tick.
  - min_pulse = sec_tick & sec_at_max.
  - hour_pulse = sec_tick & sec_at_max & min_at_max.
  - blink=0.
- key_mode pulse advances state RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
  - The transition takes effect on the next edge; set_mode reflects it 1 cycle after the pulse.
- Set states:
  - sec_tick is ignored; timekeeping is frozen.
  - blink = phase (toggles every HALF_PERIOD cycles).
  - Rising edge of key_inc (registered edge detect) produces exactly one cycle of:
    - hour_pulse in SET_HOUR;
    - min_pulse in SET_MIN;
    - sec_clear in SET_SEC.
  - No carry propagation in set states: at_max inputs are ignored.
- Exit SET_SEC->RUN:
  - Prescaler count and phase clear to 0, so the first sec_pulse occurs 2*HALF_PERIOD cycles later.
- Simultaneous events:
  - key_mode and a key_inc rising edge in the same cycle: mode change wins, the inc edge is discarded.
  - sec_tick coinciding with key_mode in RUN: the tick's pulses are still issued.
- At most one of sec_pulse/min_pulse/hour_pulse/sec_clear is driven per cycle in set states.
  - In RUN, multiple pulses may be high together (carry chain).
- Reset asserted mid-operation or mid-press: immediate return to reset state on that edge; outputs 0 next cycle.

Optional Feature:
Macro AUTO_REPEAT_EN.
- Defined:
  - A hold counter counts half_ticks while key_inc stays high in a set state; it clears when key_inc=0 or the state changes.
  - Once the count reaches REPEAT_DELAY, each further half_tick generates one extra adjustment pulse, with the same per-state mapping as a rising edge.
  - Maximum repeat rate is 2 per second.
- Undefined:
  - The hold counter is not implemented.
  - Only rising edges produce adjustments; holding key_inc produces exactly one pulse.

Test Plan:
1. HALF_PERIOD=4, reset 3 cycles, release -> all outputs 0; first sec_pulse 8 cycles after release, then every 8 cycles, each 1 cycle wide.
2. RUN with sec_at_max=1, min_at_max=1 at a sec_tick -> sec_pulse, min_pulse, hour_pulse all high in the same cycle. With min_at_max=0 -> hour_pulse stays 0.
3. Four key_mode pulses -> set_mode 1,2,3,0, each 1 cycle after its pulse. blink toggles every 4 cycles in modes 1-3 and is 0 in RUN.
4. SET_MIN, key_inc held high 20 cycles -> exactly one min_pulse without AUTO_REPEAT_EN. With AUTO_REPEAT_EN (REPEAT_DELAY=2) -> additional min_pulses every 4 cycles once hold ≥ 2 half-periods. No sec_pulse during the hold.
5. key_mode and a key_inc rising edge in the same cycle in SET_HOUR -> state becomes SET_MIN, no hour_pulse or min_pulse.
6. Reset asserted mid-hold in SET_SEC -> set_mode=0, sec_clear=0 next cycle. Prescaler restarts from 0; key_inc still high after release produces no pulse.

Source files
------------

// File: rtl/watch_time_ctrl.sv
// watch_time_ctrl: sequencing controller for the seconds, minutes and hours
// pulse-increment counters of a watch.
//  - Divides the system clock into a half-second tick and a 1 Hz tick.
//  - In RUN it issues timekeeping pulses, carrying into minutes and hours
//    when the lower counters sit at their maximum.
//  - In SET_HOUR / SET_MIN / SET_SEC a rising edge of key_inc adjusts the
//    selected field, and the selected field blinks on the half-second phase.
// Optional feature macro: AUTO_REPEAT_EN. When it is defined, holding key_inc
// auto-repeats adjustments on half ticks after REPEAT_DELAY half-periods.
module watch_time_ctrl #(
    parameter int HALF_PERIOD  = 500,
    parameter int REPEAT_DELAY = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       sec_at_max,
    input  logic       min_at_max,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic       sec_clear,
    output logic [1:0] set_mode,
    output logic       blink
);

    localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    // Guard against unusable parameter values; this block is deliberately
    // empty and only exists so that bad values stand out at elaboration.
    if (HALF_PERIOD < 2 || REPEAT_DELAY < 0) begin : g_bad_params
    end

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_t;

    mode_t            state_reg;
    mode_t            state_next;
    logic [CNT_W-1:0] count_reg;
    logic             phase_reg;
    logic             key_inc_reg;

    logic             half_tick;
    logic             sec_tick;
    logic             inc_edge;
    logic             repeat_fire;
    logic             adjust;
    logic             restart;

    logic             sec_pulse_reg;
    logic             min_pulse_reg;
    logic             hour_pulse_reg;
    logic             sec_clear_reg;
    logic             sec_pulse_next;
    logic             min_pulse_next;
    logic             hour_pulse_next;
    logic             sec_clear_next;

    assign half_tick = (count_reg == CNT_W'(HALF_PERIOD - 1));
    assign sec_tick  = half_tick & phase_reg;
    assign inc_edge  = key_inc & ~key_inc_reg;
    // A mode change in the same cycle swallows any adjustment request.
    assign adjust    = (inc_edge | repeat_fire) & ~key_mode;
    // Leaving SET_SEC restarts the time base so a full second elapses
    // before the first timekeeping pulse.
    assign restart   = (state_reg == SET_SEC) & key_mode;

`ifdef AUTO_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 2);

    logic [HOLD_W-1:0] hold_reg;

    // Count half ticks while key_inc is held in a set state; saturate at the delay.
    always_ff @(posedge clock) begin
        if (reset || key_mode || !key_inc || (state_reg == RUN)) begin
            hold_reg <= '0;
        end else if (half_tick && (hold_reg < HOLD_W'(REPEAT_DELAY))) begin
            hold_reg <= hold_reg + 1'b1;
        end
    end

    assign repeat_fire = (state_reg != RUN) & key_inc & half_tick
                         & (hold_reg >= HOLD_W'(REPEAT_DELAY));
`else
    assign repeat_fire = 1'b0;
`endif

    // Half-period prescaler and blink/second phase.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            count_reg <= '0;
            phase_reg <= 1'b0;
        end else if (half_tick) begin
            count_reg <= '0;
            phase_reg <= ~phase_reg;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Registered copy of key_inc for rising-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_inc_reg <= 1'b0;
        end else begin
            key_inc_reg <= key_inc;
        end
    end

    // Mode state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next mode and pulse selection for the current mode.
    always_comb begin
        state_next      = state_reg;
        sec_pulse_next  = 1'b0;
        min_pulse_next  = 1'b0;
        hour_pulse_next = 1'b0;
        sec_clear_next  = 1'b0;
        case (state_reg)
            RUN: begin
                sec_pulse_next  = sec_tick;
                min_pulse_next  = sec_tick & sec_at_max;
                hour_pulse_next = sec_tick & sec_at_max & min_at_max;
                if (key_mode) state_next = SET_HOUR;
            end
            SET_HOUR: begin
                hour_pulse_next = adjust;
                if (key_mode) state_next = SET_MIN;
            end
            SET_MIN: begin
                min_pulse_next = adjust;
                if (key_mode) state_next = SET_SEC;
            end
            SET_SEC: begin
                sec_clear_next = adjust;
                if (key_mode) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Output pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sec_pulse_reg  <= 1'b0;
            min_pulse_reg  <= 1'b0;
            hour_pulse_reg <= 1'b0;
            sec_clear_reg  <= 1'b0;
        end else begin
            sec_pulse_reg  <= sec_pulse_next;
            min_pulse_reg  <= min_pulse_next;
            hour_pulse_reg <= hour_pulse_next;
            sec_clear_reg  <= sec_clear_next;
        end
    end

    assign sec_pulse  = sec_pulse_reg;
    assign min_pulse  = min_pulse_reg;
    assign hour_pulse = hour_pulse_reg;
    assign sec_clear  = sec_clear_reg;
    assign set_mode   = state_reg;
    assign blink      = (state_reg != RUN) & phase_reg;

endmodule
